// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline memory-port logic.
//   - default address/data widths
//   - arbiter state and owner encodings
//   - latency counter width and legal MEM_LAT ceiling
//   - pick_owner: contention rule between fetch and data requests
package cpu_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int LAT_CNT_W   = 4;
  localparam int MEM_LAT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Data wins unless it won last time and fetch is also waiting.
  // Only meaningful when at least one request is pending.
  function automatic owner_t pick_owner(input logic if_pend, input logic dm_pend,
                                        input owner_t last);
    if (dm_pend && (!if_pend || last == OWN_IF)) return OWN_DM;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times the fixed memory latency.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load        load load_val this cycle (takes priority over dec)
//   load_val    start value
//   dec         count down this cycle
//   done        high in the dec cycle in which the count reaches zero
module mem_lat_counter
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 done
);

  logic [LAT_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Terminal count: this decrement takes the counter to zero.
  assign done = dec && (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (if_*) and the
// data-memory stage (dm_*). Requests are serialised, each access strobes
// mem_en for one cycle, read data is captured MEM_LAT cycles later and the
// owner gets a one-cycle valid pulse. pipe_stall holds the pipeline while
// either requester is still waiting.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr                  fetch request (level) and PC
//   if_rdata/if_valid               fetched word and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata   data request (level), store flag, addr, data
//   dm_rdata/dm_valid               load data and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory strobe and command
//   mem_rdata                       memory read data (MEM_LAT after mem_en)
//   pipe_stall                      global pipeline freeze
//
// state | meaning
// IDLE  | choose a requester, latch its command
// ISSUE | mem_en for one cycle, start latency counter
// WAIT  | count down; capture mem_rdata on terminal count
// RESP  | pulse owner's valid, then back to IDLE
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pipe_stall
);

  if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside 1..%0d", MEM_LAT, MEM_LAT_MAX);
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LAT);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, grant_own;
  logic              if_pend, dm_pend, any_pend;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              cnt_load, cnt_dec, cnt_done;

  // A requester whose valid is high this cycle has just been served.
  assign if_pend   = if_req & ~if_valid;
  assign dm_pend   = dm_req & ~dm_valid;
  assign any_pend  = if_pend | dm_pend;
  // owner_q keeps the last winner after the access ends, so it doubles as
  // the last-grant history used for alternation.
  assign grant_own = pick_owner(if_pend, dm_pend, owner_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    if_valid = 1'b0;
    dm_valid = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ISSUE: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        cnt_load = 1'b1;
      end
      WAIT:  cnt_dec = 1'b1;
      RESP: begin
        if_valid = (owner_q == OWN_IF);
        dm_valid = (owner_q == OWN_DM);
      end
      default: ;
    endcase
  end

  // Command latch: requester inputs are only sampled at the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (state_q == IDLE && any_pend) begin
      owner_q <= grant_own;
      if (grant_own == OWN_DM) begin
        addr_q  <= dm_addr;
        we_q    <= dm_we;
        wdata_q <= dm_wdata;
      end else begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
      end
    end
  end

  // Read-data capture; stores leave dm_rdata untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (state_q == WAIT && cnt_done) begin
      if (owner_q == OWN_IF)  if_rdata_q <= mem_rdata;
      else if (!we_q)         dm_rdata_q <= mem_rdata;
    end
  end

  mem_lat_counter u_lat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign if_rdata   = if_rdata_q;
  assign dm_rdata   = dm_rdata_q;
  assign pipe_stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct { int cyc; logic [31:0] addr; logic we; logic [31:0] wdata; } iss_t;
  typedef struct { int cyc; logic [31:0] data; } rsp_t;
  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } dreq_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT (MEM_LAT = 2)
  logic        rst_n, if_req, if_valid, dm_req, dm_we, dm_valid;
  logic        mem_en, mem_we, pipe_stall;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pipe_stall(pipe_stall)
  );

  // latency corner DUTs: index 0 -> MEM_LAT=1, index 1 -> MEM_LAT=15
  logic        aux_rst_n;
  logic [1:0]  aux_if_req, aux_if_valid, aux_dm_valid, aux_mem_en, aux_mem_we, aux_stall;
  logic [31:0] aux_if_addr [2];
  logic [31:0] aux_if_rdata [2];
  logic [31:0] aux_dm_rdata [2];
  logic [31:0] aux_mem_addr [2];
  logic [31:0] aux_mem_wdata [2];
  logic [31:0] aux_mem_rdata [2];

  for (genvar g = 0; g < 2; g++) begin : g_aux
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 15)) u_aux (
      .clk(clk), .rst_n(aux_rst_n),
      .if_req(aux_if_req[g]), .if_addr(aux_if_addr[g]), .if_rdata(aux_if_rdata[g]),
      .if_valid(aux_if_valid[g]),
      .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
      .dm_rdata(aux_dm_rdata[g]), .dm_valid(aux_dm_valid[g]),
      .mem_en(aux_mem_en[g]), .mem_we(aux_mem_we[g]), .mem_addr(aux_mem_addr[g]),
      .mem_wdata(aux_mem_wdata[g]), .mem_rdata(aux_mem_rdata[g]), .pipe_stall(aux_stall[g])
    );
  end

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // ---------------- memory environment and reference model ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h10)  return 32'h8C22_0004;
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] rd_sched [int];

  function automatic logic [31:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  iss_t exp_iss [$];
  rsp_t exp_if [$];
  rsp_t exp_dm [$];

  int          free_at = 0;
  bit          last_dm = 1'b0;
  logic [31:0] mdl_dm_rdata = 32'h0;
  int          if_done_at = -1, dm_done_at = -1;

  // requester state
  bit          if_got, dm_got, if_granted, dm_granted, stop_new;
  int          if_gap, dm_gap, gap_max, n_done;
  logic [31:0] if_dir [$];
  dreq_t       dm_dir [$];

  task automatic model_step();
    bit   to_dm;
    int   done;
    iss_t ie;
    rsp_t re;
    if (cyc >= free_at && (if_req || dm_req)) begin
      to_dm = dm_req && (!if_req || !last_dm);
      done  = cyc + LAT + 2;
      if (to_dm) begin
        ie = '{cyc + 1, dm_addr, dm_we, dm_wdata};
        if (dm_we) ref_mem[dm_addr] = dm_wdata;
        else       mdl_dm_rdata = ref_rd(dm_addr);
        re = '{done, mdl_dm_rdata};
        exp_dm.push_back(re);
        dm_done_at = done;
        dm_granted = 1'b1;
      end else begin
        ie = '{cyc + 1, if_addr, 1'b0, 32'h0};
        re = '{done, ref_rd(if_addr)};
        exp_if.push_back(re);
        if_done_at = done;
        if_granted = 1'b1;
      end
      exp_iss.push_back(ie);
      last_dm = to_dm;
      free_at = cyc + LAT + 3;
    end
  endtask

  task automatic drive_cycle();
    dreq_t d;
    mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
    if (if_got) begin
      if_req = 1'b0; if_got = 1'b0; if_granted = 1'b0;
      if_gap = $urandom_range(0, gap_max);
    end
    if (if_req) begin
      if (if_granted) if_addr = $urandom;
    end else if (!stop_new) begin
      if (if_gap == 0) begin
        if_req  = 1'b1;
        if_addr = (if_dir.size() > 0) ? if_dir.pop_front() : ($urandom_range(0, 63) << 2);
      end else begin
        if_gap--;
      end
    end
    if (dm_got) begin
      dm_req = 1'b0; dm_got = 1'b0; dm_granted = 1'b0;
      dm_gap = $urandom_range(0, gap_max);
    end
    if (dm_req) begin
      if (dm_granted) begin
        dm_addr = $urandom; dm_we = ~dm_we; dm_wdata = $urandom;
      end
    end else if (!stop_new) begin
      if (dm_gap == 0) begin
        if (dm_dir.size() > 0) begin
          d = dm_dir.pop_front();
        end else begin
          d.we    = 1'($urandom_range(0, 1));
          d.addr  = ($urandom_range(0, 3) == 0) ? 32'h200 : 32'h100 + ($urandom_range(0, 15) << 2);
          d.wdata = $urandom;
        end
        dm_req = 1'b1; dm_we = d.we; dm_addr = d.addr; dm_wdata = d.wdata;
      end else begin
        dm_gap--;
      end
    end
  endtask

  task automatic observe_cycle();
    if (mem_en) begin
      rd_sched[cyc + LAT] = env_rd(mem_addr);
      if (mem_we) env_mem[mem_addr] = mem_wdata;
    end
    check("pipe_stall", 32'(pipe_stall),
          32'((if_req && cyc != if_done_at) || (dm_req && cyc != dm_done_at)));
    if (if_valid) begin if_got = 1'b1; n_done++; end
    if (dm_valid) begin dm_got = 1'b1; n_done++; end
    model_step();
  endtask

  task automatic run_cycle();
    drive_cycle();
    @(negedge clk);
    observe_cycle();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit quiet;
    stop_new = 1'b1;
    quiet = 1'b0;
    for (int n = 0; n < 200; n++) begin
      quiet = !if_req && !dm_req && cyc >= free_at &&
              exp_iss.size() == 0 && exp_if.size() == 0 && exp_dm.size() == 0;
      if (quiet) break;
      run_cycle();
    end
    check("drain_quiet", 32'(quiet), 32'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin : mon
    iss_t ie;
    rsp_t re;
    if (rst_n) begin
      if (mem_en) begin
        check("mem_en_expected", 32'(exp_iss.size() > 0), 32'd1);
        if (exp_iss.size() > 0) begin
          ie = exp_iss.pop_front();
          check("mem_en_cycle", cyc, ie.cyc);
          check("mem_addr", mem_addr, ie.addr);
          check("mem_we", 32'(mem_we), 32'(ie.we));
          if (ie.we) check("mem_wdata", mem_wdata, ie.wdata);
        end
      end else begin
        check("mem_we_idle", 32'(mem_we), 32'd0);
      end
      if (if_valid) begin
        check("if_valid_expected", 32'(exp_if.size() > 0), 32'd1);
        if (exp_if.size() > 0) begin
          re = exp_if.pop_front();
          check("if_valid_cycle", cyc, re.cyc);
          check("if_rdata", if_rdata, re.data);
        end
      end
      if (dm_valid) begin
        check("dm_valid_expected", 32'(exp_dm.size() > 0), 32'd1);
        if (exp_dm.size() > 0) begin
          re = exp_dm.pop_front();
          check("dm_valid_cycle", cyc, re.cyc);
          check("dm_rdata", dm_rdata, re.data);
        end
      end
    end
  end

  // ---------------- latency corner test ----------------
  task automatic lone_fetch(input int i, input int lat, input logic [31:0] a,
                            input logic [31:0] d);
    int t, e, v, n_en;
    t = cyc; e = -1; v = -1; n_en = 0;
    aux_if_req[i]  = 1'b1;
    aux_if_addr[i] = a;
    aux_mem_rdata[i] = $urandom;
    @(negedge clk);
    check("aux_stall_req", 32'(aux_stall[i]), 32'd1);
    for (int n = 0; n < 40; n++) begin
      if (aux_mem_en[i]) begin
        n_en++;
        if (e < 0) begin
          e = cyc;
          check("aux_mem_addr", aux_mem_addr[i], a);
          check("aux_mem_we", 32'(aux_mem_we[i]), 32'd0);
        end
      end
      if (aux_if_valid[i]) begin
        v = cyc;
        check("aux_if_rdata", aux_if_rdata[i], d);
        break;
      end
      @(posedge clk); #1;
      aux_mem_rdata[i] = (e >= 0 && cyc == e + lat) ? d : $urandom;
      @(negedge clk);
    end
    check("aux_mem_en_offset", e - t, 32'd1);
    check("aux_mem_en_count", n_en, 32'd1);
    check("aux_valid_offset", v - t, lat + 2);
    @(posedge clk); #1;
    aux_if_req[i] = 1'b0;
    @(negedge clk);
    check("aux_stall_idle", 32'(aux_stall[i]), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int g;
    rst_n = 1'b0; aux_rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    aux_if_req = '0;
    for (int i = 0; i < 2; i++) begin aux_if_addr[i] = '0; aux_mem_rdata[i] = '0; end
    if_got = 0; dm_got = 0; if_granted = 0; dm_granted = 0; stop_new = 0;
    if_gap = 0; dm_gap = 0; gap_max = 0; n_done = 0;
    if_dir.push_back(32'h10);
    dm_dir.push_back('{1'b0, 32'h100, 32'h0});
    dm_dir.push_back('{1'b1, 32'h200, 32'h1234_5678});
    dm_dir.push_back('{1'b0, 32'h200, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_dm_valid", 32'(dm_valid), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_pipe_stall", 32'(pipe_stall), 32'd0);

    @(posedge clk); #1;
    rst_n = 1'b1; aux_rst_n = 1'b1;
    free_at = cyc;

    // both requesters raised together and held: strict alternation, dm first
    for (int n = 0; n < 300 && n_done < 6; n++) run_cycle();
    check("alternation_done", 32'(n_done >= 6), 32'd1);

    gap_max = 3;
    repeat (400) run_cycle();
    drain();

    // reset during WAIT of a fetch, request kept high across reset
    if_req = 1'b1; if_addr = 32'h20; g = 0;
    for (int n = 0; n < 20; n++) begin
      drive_cycle();
      @(negedge clk);
      observe_cycle();
      if (if_granted && cyc == if_done_at - LAT) begin g = 1; break; end
      @(posedge clk); #1;
    end
    check("reset_test_reached_wait", g, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_if_valid", 32'(if_valid), 32'd0);
    check("mid_rst_dm_valid", 32'(dm_valid), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'd0);
    check("mid_rst_mem_wdata", mem_wdata, 32'd0);
    check("mid_rst_if_rdata", if_rdata, 32'd0);
    check("mid_rst_dm_rdata", dm_rdata, 32'd0);
    check("mid_rst_pipe_stall", 32'(pipe_stall), 32'd1);
    exp_iss.delete(); exp_if.delete(); exp_dm.delete();
    last_dm = 1'b0; mdl_dm_rdata = 32'h0;
    if_granted = 1'b0; dm_granted = 1'b0; if_got = 1'b0; dm_got = 1'b0;
    if_done_at = -1; dm_done_at = -1;
    if_addr = 32'h24;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    free_at = cyc;
    drain();

    lone_fetch(0, 1, 32'h40, 32'hA5A5_1234);
    lone_fetch(1, 15, 32'h44, 32'h0BAD_F00D);
    check("aux0_dm_valid", 32'(aux_dm_valid[0]), 32'd0);
    check("aux1_dm_rdata", aux_dm_rdata[1], 32'd0);
    check("aux1_mem_wdata", aux_mem_wdata[1], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin : watchdog
    #500000;
    nerr++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch stage and the data-memory stage of the five-stage pipeline. The arbiter serialises fetch and load/store requests onto the port and applies a fixed memory latency. It returns read data or write completion to the winning requester and drives a global stall while either stage is waiting. It sits between the IF/MEM stage logic and the unified memory, and replaces the separate instruction and data memories.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address (the PC)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- dm_valid  out  1  one-cycle completion pulse for loads and stores
- mem_en  out  1  one-cycle memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
- pipe_stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB

## Operation
- State machine: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** evaluate requests. A requester whose valid is high this cycle is ignored.
  - Only one request pending: grant it.
  - Both pending: grant dm, unless the previous grant was dm, in which case grant if. This gives strict alternation under contention, with data first from reset.
  - On any grant, latch the owner, address, we and wdata, then go to ISSUE.
- **ISSUE:** drive mem_en=1 with the latched address, we and wdata for exactly one cycle. Load the latency counter with MEM_LAT and go to WAIT.
- **WAIT:** decrement the counter. When it reaches 0, capture mem_rdata into the owner's rdata register and go to RESP. Capture occurs in the cycle that is MEM_LAT cycles after ISSUE.
- **RESP:** pulse the owner's valid for one cycle and return to IDLE.
  - The other requester may be granted in the IDLE cycle that follows.
  - The rdata register holds its value until the next completion for that owner.
- **Stores:** same sequence. dm_valid pulses and dm_rdata is left unchanged.
- **Outputs outside ISSUE:** mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last values.
- **pipe_stall:** (if_req & ~if_valid) | (dm_req & ~dm_valid). Combinational from the inputs and registered valids.
- **Requester inputs:** changes while a request is granted are ignored, because the latched copies are used.

## Timing
- Reset values:
  - State IDLE, last-grant = if.
  - if_valid=0, dm_valid=0, mem_en=0, mem_we=0.
  - mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0.
  - pipe_stall follows its equation (0 while the requests are low).
- Uncontended latency: request seen in IDLE at cycle t gives mem_en at t+1, capture at t+1+MEM_LAT, valid at t+2+MEM_LAT. Each access occupies MEM_LAT+3 cycles including IDLE.
- Both requests raised at cycle 0 with MEM_LAT=2:
  - dm_valid at 4.
  - The IDLE at 5 grants if, and if_valid pulses at 9.
- Reset asserted mid-access: immediate return to IDLE with reset values. No valid pulse is produced. Any in-flight memory read data is discarded.
- Latency counter width is 4 bits. MEM_LAT outside 1..15 is a configuration error flagged by an elaboration-time check.

## Structure
- Shared package cpu_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - owner enum (OWN_IF, OWN_DM)
  - default ADDR_W/DATA_W constants
- One sub-module, mem_lat_counter: loadable 4-bit down-counter with a done flag. The FSM, grant logic and latches are instantiated in mem_port_arbiter.

## Test plan
- **Lone fetch:** MEM_LAT=2, if_req=1, if_addr=0x00000010, memory returns 0x8C220004 → mem_en exactly one cycle at t+1 with mem_addr=0x10. if_valid for one cycle at t+4 with if_rdata=0x8C220004. pipe_stall is high t..t+3 and low at t+4.
- **Contention:** if_req and dm_req (load 0x100, returns 0xDEADBEEF) raised together → dm_valid at t+4 with dm_rdata=0xDEADBEEF. if is granted at t+5 and if_valid pulses at t+9.
- **Alternation:** both requests held continuously for 6 accesses → grant order dm, if, dm, if, dm, if. No two consecutive mem_en pulses go to the same owner.
- **Store:** dm_we=1, dm_addr=0x200, dm_wdata=0x12345678 → a single mem_en with mem_we=1, addr 0x200 and data 0x12345678. dm_valid pulses and dm_rdata is unchanged.
- **Reset mid-WAIT:** rst_n low during WAIT → all outputs immediately at reset values. No valid pulse afterwards. With the request still high after release, the access restarts from IDLE.
- **MEM_LAT=1 and MEM_LAT=15:** uncontended valid appears at t+3 and t+17 respectively.
